// File: rtl/piece_bag_gen.sv
// Piece generator: Galois LFSR feeding a short FIFO of piece codes, with an
// optional "bag" mode that blocks repeats until every code has been dealt.
// Ports:
//   clk          system clock, all state on rising edge
//   restart_n    asynchronous active-low reset
//   seed_load    synchronous reseed + queue/bag flush (overrides next_req)
//   seed         reseed value (0 is replaced by 1)
//   mode         0 = uniform random, 1 = bag
//   next_req     consume current piece (ignored while piece_valid = 0)
//   piece_out    current piece code (3'b111 when empty)
//   piece_valid  piece_out holds a valid piece
//   preview      slot k in bits [3k+2:3k], k=0 is next after piece_out
//   queue_count  occupied queue entries
module piece_bag_gen #(
  parameter int unsigned       LFSR_W        = 16,
  parameter logic [LFSR_W-1:0] TAPS          = LFSR_W'(16'hB400),
  parameter logic [LFSR_W-1:0] SEED_DEFAULT  = LFSR_W'(16'hACE1),
  parameter int unsigned       NUM_PIECES    = 7,
  parameter int unsigned       PREVIEW_DEPTH = 3
) (
  input  logic                               clk,
  input  logic                               restart_n,
  input  logic                               seed_load,
  input  logic [LFSR_W-1:0]                  seed,
  input  logic                               mode,
  input  logic                               next_req,
  output logic [2:0]                         piece_out,
  output logic                               piece_valid,
  output logic [3*PREVIEW_DEPTH-1:0]         preview,
  output logic [$clog2(PREVIEW_DEPTH+2)-1:0] queue_count
);

  localparam int unsigned QDEPTH = PREVIEW_DEPTH + 1;
  localparam int unsigned CNT_W  = $clog2(QDEPTH + 1);

  // Bag is kept 8 wide so any 3-bit candidate indexes it; only the low
  // NUM_PIECES bits can ever be set.
  localparam logic [7:0] BAG_FULL = 8'((32'd1 << NUM_PIECES) - 32'd1);
  localparam logic [LFSR_W-1:0] SEED_RST =
    (SEED_DEFAULT == '0) ? LFSR_W'(1) : SEED_DEFAULT;
  localparam logic [2:0] EMPTY = 3'b111;

  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              valid_q, valid_d;
  logic [7:0]        bag_q, bag_d;
  logic [2:0]        q_q [QDEPTH];
  logic [2:0]        q_d [QDEPTH];

  logic [2:0]        cand;
  logic [LFSR_W-1:0] lfsr_step;
  logic [7:0]        bag_set;
  logic [CNT_W-1:0]  wr_idx;
  logic              push;
  logic              pop;

  // State registers; unoccupied queue entries always hold EMPTY so the
  // outputs can be wired straight from the registers.
  always_ff @(posedge clk or negedge restart_n) begin
    if (!restart_n) begin
      lfsr_q  <= SEED_RST;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      bag_q   <= '0;
      for (int i = 0; i < int'(QDEPTH); i++) q_q[i] <= EMPTY;
    end else begin
      lfsr_q  <= lfsr_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      bag_q   <= bag_d;
      for (int i = 0; i < int'(QDEPTH); i++) q_q[i] <= q_d[i];
    end
  end

  // Candidate selection, push/pop decision and next-state computation.
  always_comb begin
    lfsr_d    = lfsr_q;
    cnt_d     = cnt_q;
    valid_d   = valid_q;
    bag_d     = bag_q;
    q_d       = q_q;
    cand      = lfsr_q[2:0];
    lfsr_step = lfsr_q[0] ? ((lfsr_q >> 1) ^ TAPS) : (lfsr_q >> 1);
    bag_set   = bag_q | (8'd1 << cand);
    push      = 1'b0;
    pop       = 1'b0;
    wr_idx    = cnt_q;

    if (seed_load) begin
      lfsr_d  = (seed == '0) ? LFSR_W'(1) : seed;
      cnt_d   = '0;
      valid_d = 1'b0;
      bag_d   = '0;
      for (int i = 0; i < int'(QDEPTH); i++) q_d[i] = EMPTY;
    end else begin
      // Guard keeps the LFSR out of the all-zero lock-up state for any TAPS.
      lfsr_d = (lfsr_step == '0) ? LFSR_W'(1) : lfsr_step;
      // Eligibility uses the pre-pop count, so a full queue never pushes.
      push = (cnt_q < CNT_W'(QDEPTH)) && (32'(cand) < NUM_PIECES) &&
             (!mode || !bag_q[cand]);
      pop  = next_req && valid_q;

      if (pop) begin
        for (int i = 0; i < int'(QDEPTH) - 1; i++) q_d[i] = q_q[i+1];
        q_d[QDEPTH-1] = EMPTY;
      end

      if (push) begin
        wr_idx = pop ? (cnt_q - CNT_W'(1)) : cnt_q;
        for (int i = 0; i < int'(QDEPTH); i++) begin
          if (CNT_W'(i) == wr_idx) q_d[i] = cand;
        end
        if (mode) begin
          bag_d = ((bag_set & BAG_FULL) == BAG_FULL) ? 8'd0 : bag_set;
        end
      end

      if (push && !pop)      cnt_d = cnt_q + CNT_W'(1);
      else if (pop && !push) cnt_d = cnt_q - CNT_W'(1);
      valid_d = (cnt_d != '0);
    end
  end

  // Outputs are direct register taps.
  always_comb begin
    piece_out   = q_q[0];
    piece_valid = valid_q;
    queue_count = cnt_q;
    for (int k = 0; k < int'(PREVIEW_DEPTH); k++) preview[3*k +: 3] = q_q[k+1];
  end

endmodule

// File: tb/tb_piece_bag_gen.sv
// Self-checking bench for piece_bag_gen: directed vector table, reset and
// bag-permutation sequences, and random stimulus against a queue-based model.
module tb_piece_bag_gen;

  localparam int QD = 4;
  localparam int NP = 7;

  logic        clk = 1'b0;
  logic        restart_n = 1'b0;
  logic        seed_load = 1'b0;
  logic [15:0] seed = 16'h0;
  logic        mode = 1'b0;
  logic        next_req = 1'b0;
  logic [2:0]  piece_out;
  logic        piece_valid;
  logic [8:0]  preview;
  logic [2:0]  queue_count;

  piece_bag_gen dut (
    .clk(clk), .restart_n(restart_n), .seed_load(seed_load), .seed(seed),
    .mode(mode), .next_req(next_req), .piece_out(piece_out),
    .piece_valid(piece_valid), .preview(preview), .queue_count(queue_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: LFSR as an integer, queue as a SV queue, bag as bits.
  int unsigned m_lfsr;
  int          m_q[$];
  bit [NP-1:0] m_bag;

  function automatic void model_reset();
    m_lfsr = 32'hACE1;
    m_q.delete();
    m_bag = '0;
  endfunction

  function automatic void model_step(input bit sl, input int unsigned sd,
                                     input bit md, input bit nr);
    int unsigned c;
    bit elig;
    if (sl) begin
      m_lfsr = (sd == 0) ? 1 : sd;
      m_q.delete();
      m_bag = '0;
      return;
    end
    c = m_lfsr % 8;
    elig = (m_q.size() < QD) && (c < NP) && (!md || !m_bag[c]);
    if (nr && m_q.size() > 0) void'(m_q.pop_front());
    if (elig) begin
      m_q.push_back(int'(c));
      if (md) begin
        m_bag[c] = 1'b1;
        if (&m_bag) m_bag = '0;
      end
    end
    m_lfsr = (m_lfsr % 2 == 1) ? ((m_lfsr / 2) ^ 32'hB400) : (m_lfsr / 2);
    if (m_lfsr == 0) m_lfsr = 1;
  endfunction

  function automatic int exp_slot(input int idx);
    return (m_q.size() > idx) ? m_q[idx] : 7;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    int ep;
    ep = (exp_slot(3) << 6) | (exp_slot(2) << 3) | exp_slot(1);
    chk({tag, ".count"}, int'(queue_count), m_q.size());
    chk({tag, ".valid"}, int'(piece_valid), (m_q.size() > 0) ? 1 : 0);
    chk({tag, ".piece"}, int'(piece_out), exp_slot(0));
    chk({tag, ".preview"}, int'(preview), ep);
  endtask

  // One clock: drive on the falling edge, model on the rising edge, settle.
  task automatic step(input bit sl, input logic [15:0] sd, input bit md,
                      input bit nr);
    @(negedge clk);
    seed_load = sl; seed = sd; mode = md; next_req = nr;
    @(posedge clk);
    model_step(sl, int'(sd), md, nr);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".count"}, int'(queue_count), 0);
    chk({tag, ".valid"}, int'(piece_valid), 0);
    chk({tag, ".piece"}, int'(piece_out), 7);
    chk({tag, ".preview"}, int'(preview), 'h1FF);
  endtask

  typedef struct {
    bit          sl;
    logic [15:0] sd;
    bit          md;
    bit          nr;
    int          cnt;
    int          piece;
    int          valid;
    int          prev;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input bit sl, input logic [15:0] sd, input bit md,
                              input bit nr, input int cnt, input int piece,
                              input int valid, input int prev);
    vec_t v;
    v.sl = sl; v.sd = sd; v.md = md; v.nr = nr;
    v.cnt = cnt; v.piece = piece; v.valid = valid; v.prev = prev;
    tbl.push_back(v);
  endfunction

  initial begin
    int pops;
    int cycles;
    int grp[$];
    bit [6:0] seen;
    bit ok;

    // Bag mode from seed 1: pushes 1, 0, then 4 after a run of zero candidates.
    add(1, 16'h0001, 1, 0, 0, 7, 0, 'h1FF);
    add(0, 16'h0000, 1, 0, 1, 1, 1, 'h1FF);
    add(0, 16'h0000, 1, 0, 2, 1, 1, 'h1F8);
    for (int i = 0; i < 7; i++) add(0, 16'h0000, 1, 0, 2, 1, 1, 'h1F8);
    add(0, 16'h0000, 1, 0, 3, 1, 1, 'h1E0);
    add(0, 16'h0000, 1, 1, 3, 0, 1, 'h1D4);  // pop + push together
    add(0, 16'h0000, 1, 0, 4, 0, 1, 'h154);  // full
    add(0, 16'h0000, 1, 1, 3, 4, 1, 'h1EA);  // full + pop: no push
    add(0, 16'h0000, 1, 0, 4, 4, 1, 'h0EA);
    add(1, 16'h0000, 1, 1, 0, 7, 0, 'h1FF);  // seed_load beats next_req, seed 0
    add(0, 16'h0000, 1, 0, 1, 1, 1, 'h1FF);  // LFSR became 1
    add(0, 16'h0000, 1, 0, 2, 1, 1, 'h1F8);
    // Uniform mode from seed 1: pushes 1, 0, 0.
    add(1, 16'h0001, 0, 0, 0, 7, 0, 'h1FF);
    add(0, 16'h0000, 0, 0, 1, 1, 1, 'h1FF);
    add(0, 16'h0000, 0, 0, 2, 1, 1, 'h1F8);
    add(0, 16'h0000, 0, 0, 3, 1, 1, 'h1C0);

    // Reset held, then released between edges.
    model_reset();
    #22;
    chk_reset_outputs("rst");
    @(posedge clk);
    #3 restart_n = 1'b1;

    // Saturation with no consumption.
    for (int i = 0; i < 20; i++) begin
      step(0, 16'h0, 0, 0);
      chk_model("sat");
    end
    chk("sat.count20", int'(queue_count), 4);
    chk("sat.valid20", int'(piece_valid), 1);
    ok = (piece_out < 7) && (preview[2:0] < 7) && (preview[5:3] < 7) &&
         (preview[8:6] < 7);
    chk("sat.codes", int'(ok), 1);
    for (int i = 0; i < 50; i++) step(0, 16'h0, 0, 0);
    chk("sat.count70", int'(queue_count), 4);

    // Directed table.
    foreach (tbl[i]) begin
      step(tbl[i].sl, tbl[i].sd, tbl[i].md, tbl[i].nr);
      chk($sformatf("tbl%0d.count", i), int'(queue_count), tbl[i].cnt);
      chk($sformatf("tbl%0d.piece", i), int'(piece_out), tbl[i].piece);
      chk($sformatf("tbl%0d.valid", i), int'(piece_valid), tbl[i].valid);
      chk($sformatf("tbl%0d.preview", i), int'(preview), tbl[i].prev);
    end

    // Asynchronous reset mid-cycle with three queued pieces.
    chk("arst.pre_count", int'(queue_count), 3);
    #2 restart_n = 1'b0;
    #1 chk_reset_outputs("arst");
    model_reset();
    @(posedge clk);
    #1 chk_reset_outputs("arst_hold");
    #2 restart_n = 1'b1;
    step(0, 16'h0, 0, 0);
    chk_model("arst_rel");

    // Bag mode, continuous consumption: aligned groups of 7 are permutations.
    step(1, 16'h1234, 1, 0);
    pops = 0;
    cycles = 0;
    while (pops < 700 && cycles < 20000) begin
      if (piece_valid) begin
        if (piece_out == 3'b111) chk("bag.valid_empty", int'(piece_out), 0);
        grp.push_back(int'(piece_out));
        pops++;
        if (grp.size() == 7) begin
          seen = '0;
          foreach (grp[j]) if (grp[j] < 7) seen[grp[j]] = 1'b1;
          chk($sformatf("bag.grp%0d", pops / 7), int'(seen), 'h7F);
          grp.delete();
        end
      end
      step(0, 16'h0, 1, 1);
      chk_model("bag");
      cycles++;
    end
    chk("bag.pops", pops, 700);

    // Random stimulus against the model.
    for (int i = 0; i < 600; i++) begin
      bit sl;
      logic [15:0] sd;
      sl = ($urandom_range(0, 31) == 0);
      sd = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom());
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      step(sl, sd, mode, 1'($urandom_range(0, 2) == 0));
      chk_model("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/piece_bag_gen.md
PIECE_BAG_GEN -- requirements
Module: piece_bag_gen

Interface
REQ-001 SHALL have parameter LFSR_W, default 16, LFSR state width (8..32).
REQ-002 SHALL have parameter TAPS, default 16'hB400, Galois feedback mask (LFSR_W bits).
REQ-003 SHALL have parameter SEED_DEFAULT, default 16'hACE1, LFSR value at reset.
REQ-004 SHALL have parameter NUM_PIECES, default 7, number of piece codes (2..7).
REQ-005 SHALL have parameter PREVIEW_DEPTH, default 3, number of preview slots (1..6); QDEPTH = PREVIEW_DEPTH+1.
REQ-006 SHALL have ports:
clk  in  1  system clock, all state on rising edge
restart_n  in  1  asynchronous active-low reset
seed_load  in  1  synchronous reseed and flush strobe
seed  in  LFSR_W  reseed value
mode  in  1  0 = uniform random, 1 = bag (no repeat within a bag)
next_req  in  1  consume current piece
piece_out  out  3  current piece code
piece_valid  out  1  piece_out holds a valid piece
preview  out  3*PREVIEW_DEPTH  slot k in bits [3k+2:3k], k=0 is next after piece_out
queue_count  out  clog2(QDEPTH+1)  occupied queue entries

Function
REQ-007 SHALL hold an LFSR_W-bit Galois LFSR stepping every cycle: lsb=1 -> (state>>1)^TAPS, else state>>1.
REQ-008 SHALL take candidate = state[2:0] of the current (pre-step) state each cycle.
REQ-009 SHALL push the candidate when queue_count (pre-pop) < QDEPTH, candidate < NUM_PIECES, and, in mode 1, the candidate's bag bit is clear; otherwise discard it.
REQ-010 SHALL, in mode 1, set the pushed piece's bag bit; when this completes all NUM_PIECES bits, clear the whole bag in that same cycle.
REQ-011 SHALL ignore the bag in mode 0 without clearing it; a mode change takes effect the next cycle.
REQ-012 SHALL pop when next_req=1 and piece_valid=1: entries shift toward the head by one.
REQ-013 SHALL ignore next_req when piece_valid=0.
REQ-014 SHALL, on simultaneous pop and push, write the new entry at index queue_count-1, leaving queue_count unchanged.
REQ-015 SHALL NOT push when full, even when popping that cycle (push eligibility uses the pre-pop count).
REQ-016 SHALL drive piece_out = entry 0, piece_valid = (queue_count!=0), preview slot k = entry k+1.
REQ-017 SHALL drive unoccupied slots (piece_out when empty, preview beyond count) as 3'b111.
REQ-018 SHALL, on seed_load=1, load the LFSR with seed (0 replaced by 1), set queue_count=0, clear the bag; no push or pop that cycle; seed_load overrides next_req.
REQ-019 SHALL never hold LFSR state 0.
REQ-020 SHALL register all outputs; push latency is one cycle from the candidate-eligible cycle.

Reset
REQ-021 SHALL, while restart_n=0, asynchronously set LFSR=SEED_DEFAULT (0 replaced by 1), queue_count=0, bag=0, piece_valid=0, piece_out and all preview slots 3'b111.
REQ-022 SHALL start stepping on the first rising edge after restart_n deasserts; a reset mid-operation discards all queue and bag state.

Verification
REQ-023 Reset, release, no next_req for 20 cycles -> queue_count saturates at 4, piece_valid=1, all codes in 0..6; still 4 after 50 more cycles.
REQ-024 mode=1, seed_load with seed=16'h0001 -> first pushes are 1 then 0; the third piece is neither 0 nor 1.
REQ-025 mode=0, seed_load with seed=16'h0001 -> first three pushes are 1, 0, 0.
REQ-026 mode=1, next_req held high for 700 pops -> every aligned group of 7 consecutive pieces is a permutation of 0..6; no 3'b111 while piece_valid=1.
REQ-027 Full queue, next_req and seed_load together -> next cycle queue_count=0, piece_valid=0, piece_out=3'b111, LFSR=seed; seed=0 -> LFSR=1.
REQ-028 restart_n pulsed low mid-cycle with 3 queued pieces -> outputs go to reset values immediately, without waiting for a clock edge.
